// File: rtl/mac_ctrl_pkg.sv
// Shared types and constants for the MAC array sequencer.
package mac_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EXEC,
    DRAIN,
    DONE
  } state_t;

  localparam logic [1:0] INST_NOP  = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  localparam logic SEL_KEY   = 1'b0;
  localparam logic SEL_QUERY = 1'b1;

endpackage

// File: rtl/mac_array_ctrl.sv
// Key/query fetch sequencer and instruction driver for the mac_col chain.
// Optional stall-cycle counter enabled by defining MAC_CTRL_PERF_EN.
module mac_array_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int col     = 8,
  parameter int addr_w  = 4,
  parameter int mac_lat = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [addr_w-1:0] n_query,
  input  logic              ofifo_afull,
  output logic              mem_cen,
  output logic              mem_sel,
  output logic [addr_w-1:0] mem_addr,
  output logic [1:0]        inst_out,
  output logic              busy,
  output logic              done
`ifdef MAC_CTRL_PERF_EN
  ,
  output logic [15:0]       perf_stall_cnt
`endif
);

  localparam int drain_w = $clog2(col + mac_lat + 1);
  localparam logic [addr_w-1:0]  last_key   = addr_w'(col - 1);
  localparam logic [drain_w-1:0] drain_init = drain_w'(col + mac_lat);

  state_t              state, state_nx;
  logic [addr_w-1:0]   cnt, cnt_nx;
  logic [addr_w-1:0]   nq;
  logic [drain_w-1:0]  drain_cnt, drain_nx;
  logic                afull_q;
  logic                req_d, sel_d, done_d;
  logic [addr_w-1:0]   addr_d;

  // afull is registered so a high sample suppresses the request one edge later.
  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    drain_nx = drain_cnt;
    req_d    = 1'b0;
    sel_d    = SEL_KEY;
    addr_d   = '0;
    done_d   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = LOAD;
          cnt_nx   = '0;
        end
      end
      LOAD: begin
        req_d  = 1'b1;
        sel_d  = SEL_KEY;
        addr_d = cnt;
        if (cnt == last_key) begin
          cnt_nx = '0;
          if (nq == '0) begin
            state_nx = DRAIN;
            drain_nx = drain_init;
          end else begin
            state_nx = EXEC;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      EXEC: begin
        if (!afull_q) begin
          req_d  = 1'b1;
          sel_d  = SEL_QUERY;
          addr_d = cnt;
          if (cnt == nq - 1'b1) begin
            state_nx = DRAIN;
            drain_nx = drain_init;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) begin
          state_nx = DONE;
          done_d   = 1'b1;
        end else begin
          drain_nx = drain_cnt - 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      nq        <= '0;
      drain_cnt <= '0;
      afull_q   <= 1'b0;
      mem_cen   <= 1'b0;
      mem_sel   <= SEL_KEY;
      mem_addr  <= '0;
      inst_out  <= INST_NOP;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      drain_cnt <= drain_nx;
      afull_q   <= ofifo_afull;
      if (state == IDLE && start) nq <= n_query;
      mem_cen   <= req_d;
      mem_sel   <= sel_d;
      mem_addr  <= addr_d;
      // SRAM data returns one cycle after the request, so the instruction trails it.
      inst_out  <= !mem_cen ? INST_NOP : (mem_sel ? INST_EXEC : INST_LOAD);
      busy      <= (state_nx != IDLE);
      done      <= done_d;
    end
  end

`ifdef MAC_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset || (state == IDLE && start)) begin
      perf_stall_cnt <= '0;
    end else if (state == EXEC && afull_q && perf_stall_cnt != 16'hFFFF) begin
      perf_stall_cnt <= perf_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Scoreboard bench for mac_array_ctrl: directed runs, stalls, restart and reset cases.
module tb_mac_array_ctrl;
  import mac_ctrl_pkg::*;

  localparam int COL = 8;
  localparam int AW  = 4;
  localparam int LAT = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] n_query;
  logic          afull;
  logic          mem_cen;
  logic          mem_sel;
  logic [AW-1:0] mem_addr;
  logic [1:0]    inst_out;
  logic          busy;
  logic          done;
`ifdef MAC_CTRL_PERF_EN
  logic [15:0]   perf_stall_cnt;
`endif

  mac_array_ctrl #(.col(COL), .addr_w(AW), .mac_lat(LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .n_query     (n_query),
    .ofifo_afull (afull),
    .mem_cen     (mem_cen),
    .mem_sel     (mem_sel),
    .mem_addr    (mem_addr),
    .inst_out    (inst_out),
    .busy        (busy),
    .done        (done)
`ifdef MAC_CTRL_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic          sel;
    logic [AW-1:0] addr;
  } req_t;

  req_t       req_q[$];
  logic [1:0] inst_q[$];
  req_t       e_req;
  logic [1:0] e_inst;

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;
  int run_nq;
  int first_req_cyc, first_inst_cyc, last_req_cyc, done_cyc;
  int busy_cycles, done_cnt, n_exec_req, n_exec_inst, bubbles, reqs_seen, insts_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy) busy_cycles++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (inst_out != INST_NOP) begin
        insts_seen++;
        if (first_inst_cyc < 0) first_inst_cyc = cyc;
        check("inst_lag", insts_seen, reqs_seen);
        if (inst_q.size() == 0) begin
          check("inst_unexpected", 1, 0);
        end else begin
          e_inst = inst_q.pop_front();
          check("inst_out", inst_out, e_inst);
        end
        if (inst_out == INST_EXEC) n_exec_inst++;
      end else if (n_exec_inst > 0 && n_exec_inst < run_nq) begin
        bubbles++;
      end
      if (mem_cen) begin
        reqs_seen++;
        if (first_req_cyc < 0) first_req_cyc = cyc;
        last_req_cyc = cyc;
        if (req_q.size() == 0) begin
          check("req_unexpected", 1, 0);
        end else begin
          e_req = req_q.pop_front();
          check("req_sel", mem_sel, e_req.sel);
          check("req_addr", mem_addr, e_req.addr);
        end
        if (mem_sel) n_exec_req++;
      end
    end
  end

  task automatic clear_stats(input int nq);
    run_nq         = nq;
    first_req_cyc  = -1;
    first_inst_cyc = -1;
    last_req_cyc   = 0;
    done_cyc       = 0;
    busy_cycles    = 0;
    done_cnt       = 0;
    n_exec_req     = 0;
    n_exec_inst    = 0;
    bubbles        = 0;
    reqs_seen      = 0;
    insts_seen     = 0;
    req_q.delete();
    inst_q.delete();
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_mem_cen"},  mem_cen,  0);
    check({pfx, "_mem_sel"},  mem_sel,  0);
    check({pfx, "_mem_addr"}, mem_addr, 0);
    check({pfx, "_inst_out"}, inst_out, 0);
    check({pfx, "_busy"},     busy,     0);
    check({pfx, "_done"},     done,     0);
  endtask

  task automatic run(input int nq, input int stall_at, input int stall_len, input bit extra_start);
    int  t_start;
    bit  stalled;
    clear_stats(nq);
    for (int k = 0; k < COL; k++) begin
      req_q.push_back('{sel: SEL_KEY, addr: AW'(k)});
      inst_q.push_back(INST_LOAD);
    end
    for (int j = 0; j < nq; j++) begin
      req_q.push_back('{sel: SEL_QUERY, addr: AW'(j)});
      inst_q.push_back(INST_EXEC);
    end
    mon_en = 1'b1;
    @(posedge clk); #1;
    start   = 1'b1;
    n_query = AW'(nq);
    t_start = cyc + 1;
    @(posedge clk); #1;
    start   = 1'b0;
    n_query = AW'(nq + 7);
    stalled = 1'b0;
    for (int i = 0; i < 300 && done_cnt == 0; i++) begin
      @(posedge clk); #1;
      if (stall_len > 0 && !stalled && n_exec_req >= stall_at) begin
        afull = 1'b1;
        repeat (stall_len) @(posedge clk);
        #1;
        afull   = 1'b0;
        stalled = 1'b1;
      end
      if (extra_start && i == 10) begin
        start   = 1'b1;
        n_query = AW'(3);
        @(posedge clk); #1;
        start   = 1'b0;
      end
    end
    if (done_cnt == 0) check("done_timeout", 0, 1);
    repeat (20) @(posedge clk);
    #1;
    check("done_count",          done_cnt, 1);
    check("first_req_delay",     first_req_cyc - t_start, 1);
    check("first_inst_delay",    first_inst_cyc - t_start, 2);
    check("busy_cycles",         busy_cycles, 2 * COL + nq + LAT + 2 + stall_len);
    check("done_after_last_req", done_cyc - last_req_cyc, COL + LAT + 1);
    check("exec_reqs",           n_exec_req, nq);
    check("bubbles",             bubbles, stall_len);
    check("req_q_left",          req_q.size(), 0);
    check("inst_q_left",         inst_q.size(), 0);
    mon_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    afull   = 1'b0;
    n_query = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    check("reset_state", dut.state, IDLE);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Basic run, then zero queries.
    run(5, 0, 0, 1'b0);
    run(0, 0, 0, 1'b0);

    // Three-cycle almost-full stall in the middle of EXEC.
    run(5, 2, 3, 1'b0);
`ifdef MAC_CTRL_PERF_EN
    check("perf_stall_cnt", perf_stall_cnt, 3);
`endif

    // Start pulse while busy with a different n_query.
    run(5, 0, 0, 1'b1);

    // Reset in the middle of EXEC.
    clear_stats(5);
    @(posedge clk); #1;
    start   = 1'b1;
    n_query = AW'(5);
    @(posedge clk); #1;
    start   = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("midrst");
    check("midrst_state", dut.state, IDLE);
    reset = 1'b0;
    run(5, 0, 0, 1'b0);

    // Full query address range.
    run(15, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
